iobus_io_bank: RTL
==================

# iobus_io_bank

Parametrised IOBUS peripheral bank between the pipelined MCU's IOBUS and the board/bench. It provides NUM_OUT write-only output registers, NUM_IN input ports that are synchronised and readable, and an optional write-trace FIFO that a host or bench drains through a valid/ready handshake. It replaces the single fixed IOBUS_IN stimulus word with an address-decoded, multi-channel port map.

## Interface
- NUM_OUT, 4: output registers (1..16)
- NUM_IN, 4: input ports (1..16)
- BASE_ADDR, 32'h1100_0000: base of the port map
- TRACE_DEPTH, 8: trace FIFO entries (power of two, ≥2)
- CLK  in  1  sole clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- IOBUS_ADDR  in  32  MCU IO address
- IOBUS_OUT  in  32  MCU write data
- IOBUS_WR  in  1  MCU write strobe, one cycle per store
- IOBUS_IN  out  32  read data to MCU (combinational)
- PORT_IN  in  NUM_IN*32  external inputs; port j is bits [32j+31:32j]
- PORT_OUT  out  NUM_OUT*32  output registers, packed the same way
- TRACE_VALID  out  1  FIFO head valid
- TRACE_READY  in  1  consumer accepts head
- TRACE_IDX  out  4  output index of head entry
- TRACE_DATA  out  32  data of head entry
- TRACE_OVF  out  1  sticky overflow flag
- TRACE_CLR  in  1  synchronous clear of TRACE_OVF

## Operation
- Address map, word-aligned only (IOBUS_ADDR[1:0] must be 0):
  - output i: BASE_ADDR + 4*i, for i < NUM_OUT
  - input j: BASE_ADDR + 0x100 + 4*j, for j < NUM_IN
- Write: IOBUS_WR=1 with an output-i hit loads PORT_OUT[i] from IOBUS_OUT on the next edge. A miss, misaligned address, or input address is ignored: no register change, no trace push.
- Input path: each PORT_IN word passes through a 2-flop synchroniser. IOBUS_IN returns the synchronised word j on an input-j hit, and the current PORT_OUT[i] on an output-i hit (readback). Every other address returns 32'h0.
- Trace FIFO (see Configuration): every accepted output write pushes {i, IOBUS_OUT}. Pointers are log2(TRACE_DEPTH)+1 bits; full and empty are decided by the MSB compare.
- Pop when TRACE_VALID & TRACE_READY.
- Push while full without a same-cycle pop: the entry is dropped, PORT_OUT still updates, and TRACE_OVF sets.
- Push and pop in the same cycle while full: both succeed and the count is unchanged.
- Push into an empty FIFO: TRACE_VALID rises on the next edge. There is no bypass.
- TRACE_CLR and an overflow in the same cycle: set wins, TRACE_OVF=1.
- Pointers wrap modulo 2*TRACE_DEPTH.

## Timing
- Reset (RST_N=0, asynchronous): PORT_OUT=0, synchroniser flops=0, FIFO empty, TRACE_VALID=0, TRACE_IDX=0, TRACE_DATA=0, TRACE_OVF=0. IOBUS_IN then follows the address with zeroed sources.
- Reset asserted mid-operation discards all FIFO contents and register values immediately, not waiting for a clock edge. Deassertion takes effect at the first rising edge with RST_N=1.
- Write latency: 1 cycle from the IOBUS_WR edge to PORT_OUT.
- Input latency: a PORT_IN change is visible on IOBUS_IN after 2 rising edges.
- Trace latency: the entry is at the head 1 cycle after the write if the FIFO was empty. TRACE_IDX and TRACE_DATA hold stable while TRACE_VALID=1 and TRACE_READY=0.
- Back-to-back writes on consecutive cycles are all accepted.

## Configuration
- IOBUS_IO_BANK_TRACE_EN defined: the trace FIFO, handshake and overflow logic are built as described above.
- Not defined: there is no FIFO storage. TRACE_VALID, TRACE_IDX, TRACE_DATA and TRACE_OVF are tied to 0, and TRACE_READY and TRACE_CLR are ignored. Register and input behaviour is identical.

## Test plan
- Reset mid-write: hold IOBUS_WR=1 to BASE_ADDR+4 with data 32'hDEAD_BEEF, drop RST_N mid-cycle -> PORT_OUT[1]=0 immediately, TRACE_VALID=0.
- Write and readback: write 32'h0000_00A5 to BASE_ADDR+8 -> PORT_OUT[2]=32'hA5 after 1 cycle. Read the same address -> IOBUS_IN=32'hA5. Misaligned write to BASE_ADDR+9 -> no change.
- Input sync: set PORT_IN[0]=32'h0000_0002, address BASE_ADDR+0x100 -> IOBUS_IN=0 after 1 edge, 2 after 2 edges. An unmapped address -> 0.
- Trace drain (TRACE_EN): write 3 values with TRACE_READY=0 -> head stays {0, first value}. Raise TRACE_READY -> the 3 entries come out in order, then TRACE_VALID=0.
- Overflow (TRACE_EN, depth 8): 9 writes with no pop -> 8 entries retained, 9th dropped, TRACE_OVF=1, PORT_OUT holds the 9th value. Pulse TRACE_CLR -> TRACE_OVF=0.
- Full with simultaneous push/pop: with the FIFO full, write while TRACE_READY=1 -> count stays 8, the new entry lands at the tail, TRACE_OVF stays 0.

Source files
------------

// File: rtl/iobus_io_bank.sv
// Address-decoded IOBUS bank: NUM_OUT write/readback registers, NUM_IN synchronised inputs.
// Define IOBUS_IO_BANK_TRACE_EN to build the write-trace FIFO; otherwise trace outputs tie to 0.

module iobus_io_bank_sync (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] d,
    output logic [31:0] q
);
    logic [31:0] meta;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

module iobus_io_bank #(
    parameter int          NUM_OUT     = 4,
    parameter int          NUM_IN      = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h1100_0000,
    parameter int          TRACE_DEPTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [31:0]           IOBUS_ADDR,
    input  logic [31:0]           IOBUS_OUT,
    input  logic                  IOBUS_WR,
    output logic [31:0]           IOBUS_IN,
    input  logic [NUM_IN*32-1:0]  PORT_IN,
    output logic [NUM_OUT*32-1:0] PORT_OUT,
    output logic                  TRACE_VALID,
    input  logic                  TRACE_READY,
    output logic [3:0]            TRACE_IDX,
    output logic [31:0]           TRACE_DATA,
    output logic                  TRACE_OVF,
    input  logic                  TRACE_CLR
);
    logic [NUM_OUT-1:0][31:0] out_q;
    logic [NUM_IN-1:0][31:0]  sync_q;
    logic [31:0] offset, in_off;
    logic        out_hit, in_hit, wr_acc;
    logic [3:0]  out_idx, in_idx;

    // Unsigned offsets: addresses below a window wrap huge and miss naturally.
    assign offset  = IOBUS_ADDR - BASE_ADDR;
    assign in_off  = offset - 32'h100;
    assign out_hit = (offset[1:0] == 2'b00) && (offset < 32'(4 * NUM_OUT));
    assign in_hit  = (in_off[1:0] == 2'b00) && (in_off < 32'(4 * NUM_IN));
    assign out_idx = offset[5:2];
    assign in_idx  = in_off[5:2];
    assign wr_acc  = IOBUS_WR && out_hit;

    genvar g;
    generate
        for (g = 0; g < NUM_IN; g++) begin : g_sync
            iobus_io_bank_sync u_sync (
                .CLK   (CLK),
                .RST_N (RST_N),
                .d     (PORT_IN[32*g +: 32]),
                .q     (sync_q[g])
            );
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_q <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT; i++)
                if (wr_acc && out_idx == 4'(i)) out_q[i] <= IOBUS_OUT;
        end
    end

    assign PORT_OUT = out_q;

    always_comb begin
        IOBUS_IN = '0;
        for (int i = 0; i < NUM_OUT; i++)
            if (out_hit && out_idx == 4'(i)) IOBUS_IN = out_q[i];
        for (int j = 0; j < NUM_IN; j++)
            if (in_hit && in_idx == 4'(j)) IOBUS_IN = sync_q[j];
    end

`ifdef IOBUS_IO_BANK_TRACE_EN
    localparam int AW = $clog2(TRACE_DEPTH);

    logic [AW:0]                   wr_ptr, rd_ptr;
    logic [TRACE_DEPTH-1:0][35:0]  mem;
    logic                          empty, full, pop, push, ovf_set;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && TRACE_READY;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign push    = wr_acc && (!full || pop);
    assign ovf_set = wr_acc && full && !pop;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            TRACE_OVF <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (ovf_set)        TRACE_OVF <= 1'b1;
            else if (TRACE_CLR) TRACE_OVF <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {out_idx, IOBUS_OUT};
    end

    assign TRACE_VALID              = !empty;
    assign {TRACE_IDX, TRACE_DATA}  = empty ? 36'h0 : mem[rd_ptr[AW-1:0]];
`else
    logic unused_trace;
    assign unused_trace = TRACE_READY ^ TRACE_CLR;
    assign TRACE_VALID  = 1'b0;
    assign TRACE_IDX    = '0;
    assign TRACE_DATA   = '0;
    assign TRACE_OVF    = 1'b0;
`endif
endmodule
